// File: rtl/seq_shifter_if.sv
// rtl/seq_shifter_if.sv - request/response handshake bundle for the iterative shifter
interface seq_shifter_if #(
    parameter int XLEN = 32,
    parameter int SW   = $clog2(XLEN)
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_a;
    logic [SW-1:0]   in_shamt;
    logic [1:0]      in_op;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;

    modport master (
        output in_valid, in_a, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_a, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle SLL/SRL/SRA unit, at most STEP bits per cycle
// Optional flush input enabled by defining SEQ_SHIFTER_FLUSH_EN.
module seq_shifter #(
    parameter int XLEN = 32,
    parameter int STEP = 4,
    parameter int SW   = $clog2(XLEN)
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SEQ_SHIFTER_FLUSH_EN
    input  logic flush,
`endif
    seq_shifter_if.slave bus,
    output logic busy
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] shreg_q, shreg_d;
    logic [SW-1:0]   remaining_q, remaining_d;
    logic            left_q, left_d;
    logic            arith_q, arith_d;
    logic            sign_q, sign_d;

    logic            flush_w;
    logic [SW-1:0]   step_w;
    logic            fill_w;
    logic signed [XLEN:0] ext_w;
    logic signed [XLEN:0] rsh_w;
    logic [XLEN-1:0] lsh_w;

`ifdef SEQ_SHIFTER_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign step_w = (remaining_q < SW'(STEP)) ? remaining_q : SW'(STEP);
    assign fill_w = arith_q & sign_q;
    // One extra fill bit on top lets a single arithmetic shift cover both SRL and SRA.
    assign ext_w  = {fill_w, shreg_q};
    assign rsh_w  = ext_w >>> step_w;
    assign lsh_w  = shreg_q << step_w;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        remaining_d = remaining_q;
        left_d      = left_q;
        arith_d     = arith_q;
        sign_d      = sign_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && !flush_w) begin
                    shreg_d     = bus.in_a;
                    remaining_d = bus.in_shamt;
                    left_d      = (bus.in_op == 2'b00);
                    arith_d     = (bus.in_op == 2'b11);
                    sign_d      = bus.in_a[XLEN-1];
                    state_d     = (bus.in_shamt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                shreg_d     = left_q ? lsh_w : rsh_w[XLEN-1:0];
                remaining_d = remaining_q - step_w;
                if (remaining_d == '0) begin
                    state_d = S_DONE;
                end
                if (flush_w) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (flush_w || bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            remaining_q <= '0;
            left_q      <= 1'b0;
            arith_q     <= 1'b0;
            sign_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            remaining_q <= remaining_d;
            left_q      <= left_d;
            arith_q     <= arith_d;
            sign_q      <= sign_d;
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.out_result = shreg_q;
    assign busy           = (state_q != S_IDLE);
endmodule
